sram_bus_master: RTL and testbench

SRAM_BUS_MASTER -- requirements
Module: sram_bus_master

---
 rtl/sram_bus_master.sv | 167 ++++++++++++++++
 tb/tb_sram_bus_master.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_bus_master.sv
// Single-request-at-a-time master for an addr_ok/data_ok SRAM-style bus.
// Up to MAX_OUTSTANDING accepted requests may await in-order data_ok responses.
module sram_bus_master #(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wmask,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_is_write,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic [31:0] mem_rdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  output logic        proto_err
);

  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(MAX_OUTSTANDING - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_OUTSTANDING);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  state_t                     state_r;
  state_t                     state_nxt_s;
  logic                       we_r;
  logic [31:0]                addr_r;
  logic [31:0]                wdata_r;
  logic [3:0]                 wmask_r;
  logic [CW-1:0]              count_r;
  logic [PW-1:0]              wr_ptr_r;
  logic [PW-1:0]              rd_ptr_r;
  logic [MAX_OUTSTANDING-1:0] fifo_r;
  logic                       proto_err_r;
  logic                       accept_s;
  logic                       handshake_s;
  logic                       pop_s;
  logic                       stray_s;
  logic                       unused_addr_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PTR_LAST) begin
      ptr_inc = '0;
    end else begin
      ptr_inc = p + PW'(1);
    end
  endfunction

  // Byte offset never reaches the word-addressed bus.
  assign unused_addr_s = ^cmd_addr[1:0];

  assign cmd_ready   = rst_n & (state_r == IDLE) & (count_r < CNT_MAX);
  assign accept_s    = cmd_valid & cmd_ready;
  assign handshake_s = (state_r == REQ) & mem_addr_ok;
  assign pop_s       = mem_data_ok & (count_r != '0);
  assign stray_s     = mem_data_ok & (count_r == '0);

  assign mem_req      = (state_r == REQ);
  assign mem_we       = we_r;
  assign mem_address  = addr_r;
  assign mem_wdata    = wdata_r;
  assign mem_wmask    = wmask_r;
  assign rsp_valid    = pop_s;
  assign rsp_rdata    = mem_rdata;
  assign rsp_is_write = fifo_r[rd_ptr_r];
  assign proto_err    = proto_err_r;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state: hold a request until the responder takes it.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = REQ;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      REQ: begin
        if (handshake_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = REQ;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Bus fields captured at accept; loads carry zero data and mask.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_r    <= 1'b0;
      addr_r  <= 32'h0000_0000;
      wdata_r <= 32'h0000_0000;
      wmask_r <= 4'b0000;
    end else if (accept_s) begin
      we_r    <= cmd_we;
      addr_r  <= {2'b00, cmd_addr[31:2]};
      wdata_r <= cmd_we ? cmd_wdata : 32'h0000_0000;
      wmask_r <= cmd_we ? cmd_wmask : 4'b0000;
    end else begin
      we_r    <= we_r;
      addr_r  <= addr_r;
      wdata_r <= wdata_r;
      wmask_r <= wmask_r;
    end
  end

  // Outstanding tracking: in-order we-bit FIFO plus occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r  <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      fifo_r   <= '0;
    end else begin
      if (handshake_s) begin
        fifo_r[wr_ptr_r] <= we_r;
        wr_ptr_r         <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({handshake_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky flag for a completion that matches no outstanding request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      proto_err_r <= 1'b0;
    end else if (stray_s) begin
      proto_err_r <= 1'b1;
    end else begin
      proto_err_r <= proto_err_r;
    end
  end

endmodule

// File: tb/tb_sram_bus_master.sv
// Directed bench for sram_bus_master: inputs change on negedge, outputs checked 1ns later.
module tb_sram_bus_master;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wmask;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_is_write;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_rdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic        proto_err;

  int checks;
  int passed;

  sram_bus_master #(.MAX_OUTSTANDING(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_we       (cmd_we),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .cmd_wmask    (cmd_wmask),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_is_write (rsp_is_write),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_address  (mem_address),
    .mem_wdata    (mem_wdata),
    .mem_wmask    (mem_wmask),
    .mem_rdata    (mem_rdata),
    .mem_addr_ok  (mem_addr_ok),
    .mem_data_ok  (mem_data_ok),
    .proto_err    (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    @(negedge clk);
    cmd_valid = 1'b1;
    #1;
    checks++; if ({mem_req, mem_we, mem_address, mem_wdata, mem_wmask} !== 70'h0) $display("FAIL reset_bus: got %h exp 0", {mem_req, mem_we, mem_address, mem_wdata, mem_wmask}); else passed++;
    checks++; if (cmd_ready !== 1'b0) $display("FAIL reset_cmd_ready: got %b exp 0", cmd_ready); else passed++;
    checks++; if ({rsp_valid, proto_err} !== 2'b00) $display("FAIL reset_rsp_err: got %b exp 00", {rsp_valid, proto_err}); else passed++;
    @(negedge clk);
    cmd_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    checks++; if (cmd_ready !== 1'b1) $display("FAIL reset_release_ready: got %b exp 1", cmd_ready); else passed++;
  endtask

  task automatic test_load();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h0000_1008;
    cmd_wdata = 32'hFFFF_FFFF; cmd_wmask = 4'hF;
    #1;
    checks++; if (cmd_ready !== 1'b1) $display("FAIL load_ready: got %b exp 1", cmd_ready); else passed++;
    @(negedge clk);
    cmd_valid = 1'b0; mem_addr_ok = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b1) $display("FAIL load_mem_req: got %b exp 1", mem_req); else passed++;
    checks++; if (mem_address !== 32'h0000_0402) $display("FAIL load_address: got %h exp 00000402", mem_address); else passed++;
    checks++; if ({mem_we, mem_wdata, mem_wmask} !== 37'h0) $display("FAIL load_zero_fields: got %h exp 0", {mem_we, mem_wdata, mem_wmask}); else passed++;
    checks++; if (cmd_ready !== 1'b0) $display("FAIL load_busy_ready: got %b exp 0", cmd_ready); else passed++;
    @(negedge clk);
    mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    #1;
    checks++; if (mem_req !== 1'b0) $display("FAIL load_req_drop: got %b exp 0", mem_req); else passed++;
    checks++; if ({rsp_valid, rsp_is_write} !== 2'b10) $display("FAIL load_rsp: got %b exp 10", {rsp_valid, rsp_is_write}); else passed++;
    checks++; if (rsp_rdata !== 32'hDEAD_BEEF) $display("FAIL load_rdata: got %h exp deadbeef", rsp_rdata); else passed++;
    @(negedge clk);
    mem_data_ok = 1'b0;
    #1;
    checks++; if ({rsp_valid, proto_err} !== 2'b00) $display("FAIL load_after: got %b exp 00", {rsp_valid, proto_err}); else passed++;
  endtask

  task automatic test_store_stall();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 32'h0000_0020;
    cmd_wdata = 32'h1234_5678; cmd_wmask = 4'b0011;
    #1;
    checks++; if (cmd_ready !== 1'b1) $display("FAIL store_ready: got %b exp 1", cmd_ready); else passed++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cmd_valid = (i < 3); cmd_we = 1'b0; cmd_addr = 32'hFFFF_FFF0;
      cmd_wdata = 32'h0BAD_0BAD; cmd_wmask = 4'b1100;
      mem_addr_ok = (i == 3);
      #1;
      checks++; if ({cmd_ready, mem_req, mem_we, mem_address, mem_wdata, mem_wmask} !== {1'b0, 1'b1, 1'b1, 32'h0000_0008, 32'h1234_5678, 4'b0011})
        $display("FAIL store_stable_%0d: got %h exp %h", i, {cmd_ready, mem_req, mem_we, mem_address, mem_wdata, mem_wmask}, {1'b0, 1'b1, 1'b1, 32'h0000_0008, 32'h1234_5678, 4'b0011}); else passed++;
    end
    @(negedge clk);
    cmd_valid = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h0;
    #1;
    checks++; if ({mem_req, rsp_valid, rsp_is_write} !== 3'b011) $display("FAIL store_rsp: got %b exp 011", {mem_req, rsp_valid, rsp_is_write}); else passed++;
    @(negedge clk);
    mem_data_ok = 1'b0;
    #1;
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h0000_0100;
    #1;
    checks++; if (cmd_ready !== 1'b1) $display("FAIL bp_ready0: got %b exp 1", cmd_ready); else passed++;
    @(negedge clk);
    cmd_valid = 1'b0; mem_addr_ok = 1'b1;
    #1;
    @(negedge clk);
    mem_addr_ok = 1'b0; cmd_valid = 1'b1; cmd_addr = 32'h0000_0104;
    #1;
    checks++; if (cmd_ready !== 1'b1) $display("FAIL bp_ready1: got %b exp 1", cmd_ready); else passed++;
    @(negedge clk);
    cmd_valid = 1'b0; mem_addr_ok = 1'b1;
    #1;
    checks++; if (mem_address !== 32'h0000_0041) $display("FAIL bp_addr1: got %h exp 00000041", mem_address); else passed++;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      mem_addr_ok = 1'b0; cmd_valid = 1'b1; cmd_addr = 32'h0000_0108;
      #1;
      checks++; if (cmd_ready !== 1'b0) $display("FAIL bp_full_%0d: got %b exp 0", i, cmd_ready); else passed++;
    end
    @(negedge clk);
    mem_data_ok = 1'b1; mem_rdata = 32'h0000_000A;
    #1;
    checks++; if ({rsp_valid, cmd_ready} !== 2'b10) $display("FAIL bp_first_rsp: got %b exp 10", {rsp_valid, cmd_ready}); else passed++;
    checks++; if (rsp_rdata !== 32'h0000_000A) $display("FAIL bp_rdata_a: got %h exp 0000000a", rsp_rdata); else passed++;
    @(negedge clk);
    mem_data_ok = 1'b0;
    #1;
    checks++; if (cmd_ready !== 1'b1) $display("FAIL bp_restored: got %b exp 1", cmd_ready); else passed++;
    @(negedge clk);
    cmd_valid = 1'b0; mem_addr_ok = 1'b1;
    #1;
    checks++; if ({mem_req, mem_address} !== {1'b1, 32'h0000_0042}) $display("FAIL bp_third_req: got %h exp 100000042", {mem_req, mem_address}); else passed++;
    @(negedge clk);
    mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h0000_000B;
    #1;
    checks++; if ({rsp_valid, cmd_ready, rsp_rdata} !== {2'b10, 32'h0000_000B}) $display("FAIL bp_rsp_b: got %h exp %h", {rsp_valid, cmd_ready, rsp_rdata}, {2'b10, 32'h0000_000B}); else passed++;
    @(negedge clk);
    mem_rdata = 32'h0000_000C;
    #1;
    checks++; if ({rsp_valid, rsp_rdata} !== {1'b1, 32'h0000_000C}) $display("FAIL bp_rsp_c: got %h exp %h", {rsp_valid, rsp_rdata}, {1'b1, 32'h0000_000C}); else passed++;
    @(negedge clk);
    mem_data_ok = 1'b0;
    #1;
    checks++; if ({proto_err, cmd_ready} !== 2'b01) $display("FAIL bp_drained: got %b exp 01", {proto_err, cmd_ready}); else passed++;
  endtask

  task automatic test_in_order();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 32'h0000_0040;
    cmd_wdata = 32'h0000_CAFE; cmd_wmask = 4'hF;
    #1;
    checks++; if (cmd_ready !== 1'b1) $display("FAIL order_ready: got %b exp 1", cmd_ready); else passed++;
    @(negedge clk);
    cmd_valid = 1'b0; mem_addr_ok = 1'b1;
    #1;
    @(negedge clk);
    mem_addr_ok = 1'b0; cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h0000_0044;
    #1;
    @(negedge clk);
    cmd_valid = 1'b0; mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'h0;
    #1;
    checks++; if ({mem_req, rsp_valid, rsp_is_write} !== 3'b111) $display("FAIL order_first: got %b exp 111", {mem_req, rsp_valid, rsp_is_write}); else passed++;
    @(negedge clk);
    mem_addr_ok = 1'b0; mem_rdata = 32'h0000_5555;
    #1;
    checks++; if ({rsp_valid, rsp_is_write, rsp_rdata} !== {2'b10, 32'h0000_5555}) $display("FAIL order_second: got %h exp %h", {rsp_valid, rsp_is_write, rsp_rdata}, {2'b10, 32'h0000_5555}); else passed++;
    @(negedge clk);
    mem_data_ok = 1'b0;
    #1;
    checks++; if ({rsp_valid, proto_err} !== 2'b00) $display("FAIL order_done: got %b exp 00", {rsp_valid, proto_err}); else passed++;
  endtask

  task automatic test_proto_err();
    @(negedge clk);
    mem_data_ok = 1'b1;
    #1;
    checks++; if ({rsp_valid, proto_err, cmd_ready} !== 3'b001) $display("FAIL proto_pulse: got %b exp 001", {rsp_valid, proto_err, cmd_ready}); else passed++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_data_ok = 1'b0;
      #1;
      checks++; if ({proto_err, cmd_ready} !== 2'b11) $display("FAIL proto_sticky_%0d: got %b exp 11", i, {proto_err, cmd_ready}); else passed++;
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h0000_0200;
    #1;
    checks++; if (cmd_ready !== 1'b1) $display("FAIL rmid_ready: got %b exp 1", cmd_ready); else passed++;
    @(negedge clk);
    cmd_valid = 1'b0; mem_addr_ok = 1'b1;
    #1;
    @(negedge clk);
    mem_addr_ok = 1'b0; cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 32'h0000_0300;
    cmd_wdata = 32'h0000_0001; cmd_wmask = 4'b0001;
    #1;
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    checks++; if ({mem_req, mem_we, proto_err} !== 3'b111) $display("FAIL rmid_held: got %b exp 111", {mem_req, mem_we, proto_err}); else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({mem_req, mem_we, mem_address, mem_wdata, mem_wmask} !== 70'h0) $display("FAIL rmid_bus_clear: got %h exp 0", {mem_req, mem_we, mem_address, mem_wdata, mem_wmask}); else passed++;
    checks++; if ({cmd_ready, rsp_valid, proto_err} !== 3'b000) $display("FAIL rmid_ctrl_clear: got %b exp 000", {cmd_ready, rsp_valid, proto_err}); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if ({cmd_ready, mem_req} !== 2'b10) $display("FAIL rmid_release: got %b exp 10", {cmd_ready, mem_req}); else passed++;
    @(negedge clk);
    mem_data_ok = 1'b1;
    #1;
    checks++; if (rsp_valid !== 1'b0) $display("FAIL rmid_no_rsp: got %b exp 0", rsp_valid); else passed++;
    @(negedge clk);
    mem_data_ok = 1'b0;
    #1;
    checks++; if (proto_err !== 1'b1) $display("FAIL rmid_proto: got %b exp 1", proto_err); else passed++;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0; cmd_wmask = 4'h0;
    mem_rdata = 32'h0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    test_reset();
    test_load();
    test_store_stall();
    test_backpressure();
    test_in_order();
    test_proto_err();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
